ising_recursive_matrix: RTL and testbench

- Synthesizable, fully clocked N×N coupling array for the digital Ising machine.
- Built recursively from four N/2 quadrants down to 1×1 leaf cells. Leaves are shorted (spin) cells on the diagonal and weighted coupled cells elsewhere.
- Carries spin phase signals between rows and columns, and holds an AXI-writable weight per coupled cell.
- Instantiated by the core matrix, which loops rout→tin and tout→rin externally.

---
 rtl/ising_recursive_matrix.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_ising_recursive_matrix.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ising_recursive_matrix.sv
`default_nettype none
// ============================================================================
// Module  : ising_recursive_matrix (with leaf ising_cell)
// Purpose : N x N coupling array for the digital Ising machine. The array is
//           built by splitting into four N/2 quadrants until 1x1 leaf cells
//           remain. Diagonal leaves of a DIAGONAL instance are shorted (spin)
//           cells. Every other leaf is a coupled cell that holds a weight and
//           delays phase edges according to that weight.
// Ports   : clk          - single clock, rising edge
//           axi_rstn     - sync active-low reset of weight registers
//           ising_rstn   - sync active-low reset of phase regs / counters
//           lin/rin      - per-row rightward / leftward phase inputs
//           tin/bin      - per-column downward / upward phase inputs
//           lout/rout    - per-row leftward / rightward phase outputs
//           tout/bout    - per-column upward / downward phase outputs
//           right_col    - per-row spin (diagonal A, or rout)
//           wready       - write strobe
//           wr_match     - address decoded as weight space
//           s_addr       - source index (column), d_addr - dest index (row)
//           vh           - s_addr > d_addr, carried down, not decoded
//           wdata/rdata  - weight write data / combinational read data
// Rev     : 1.0 - initial release
// ============================================================================
module ising_cell #(
  parameter bit SHORTED     = 1'b0,
  parameter int NUM_WEIGHTS = 5
) (
  input  logic        clk,
  input  logic        axi_rstn,
  input  logic        ising_rstn,
  input  logic        lin,
  input  logic        rin,
  input  logic        tin,
  input  logic        bin,
  output logic        lout,
  output logic        rout,
  output logic        tout,
  output logic        bout,
  output logic        spin,
  input  logic        we,
  input  logic        rd_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  if (SHORTED) begin : g_shorted
    // Spin cell: each register inverts the phase arriving along its path.
    logic r_a;
    logic r_b;
    logic w_unused;

    always_ff @(posedge clk) begin
      if (!ising_rstn) begin
        r_a <= 1'b0;
        r_b <= 1'b0;
      end else begin
        r_a <= ~tin;
        r_b <= ~rin;
      end
    end

    assign rout  = r_a;
    assign bout  = r_a;
    assign tout  = r_b;
    assign lout  = r_b;
    assign spin  = r_a;
    assign rdata = '0;
    assign w_unused = ^{lin, bin, we, rd_sel, wdata};
  end else begin : g_coupled
    localparam int WW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
    localparam int CW = $clog2(NUM_WEIGHTS + 1);
    localparam logic [WW-1:0] W_MAX     = WW'(NUM_WEIGHTS - 1);
    localparam logic [WW-1:0] W_NEUTRAL = WW'((NUM_WEIGHTS - 1) / 2);

    logic [WW-1:0] r_w;
    logic          r_down;
    logic          r_up;
    logic          r_rout;
    logic          r_lout;
    logic [CW-1:0] r_rcnt;
    logic [CW-1:0] r_lcnt;
    logic [CW-1:0] w_rdelay;
    logic [CW-1:0] w_ldelay;
    logic          w_unused;

    // Agreement with the crossing vertical phase selects w, disagreement
    // selects its mirror image around the neutral level.
    assign w_rdelay = CW'(1) + ((lin == tin) ? CW'(r_w) : CW'(W_MAX - r_w));
    assign w_ldelay = CW'(1) + ((rin == bin) ? CW'(r_w) : CW'(W_MAX - r_w));

    always_ff @(posedge clk) begin
      if (!axi_rstn) begin
        r_w <= W_NEUTRAL;
      end else if (we) begin
        r_w <= (wdata[WW-1:0] > W_MAX) ? W_MAX : wdata[WW-1:0];
      end
    end

    // The counters count edges on which the input differs from the output;
    // the D-th such edge commits the change. D is re-evaluated every edge,
    // so a weight or agreement change takes effect mid-count.
    always_ff @(posedge clk) begin
      if (!ising_rstn) begin
        r_down <= 1'b0;
        r_up   <= 1'b0;
        r_rout <= 1'b0;
        r_lout <= 1'b0;
        r_rcnt <= '0;
        r_lcnt <= '0;
      end else begin
        r_down <= tin;
        r_up   <= bin;

        if (lin == r_rout) begin
          r_rcnt <= '0;
        end else if (r_rcnt + CW'(1) >= w_rdelay) begin
          r_rout <= lin;
          r_rcnt <= '0;
        end else begin
          r_rcnt <= r_rcnt + CW'(1);
        end

        if (rin == r_lout) begin
          r_lcnt <= '0;
        end else if (r_lcnt + CW'(1) >= w_ldelay) begin
          r_lout <= rin;
          r_lcnt <= '0;
        end else begin
          r_lcnt <= r_lcnt + CW'(1);
        end
      end
    end

    assign bout  = r_down;
    assign tout  = r_up;
    assign rout  = r_rout;
    assign lout  = r_lout;
    assign spin  = r_rout;
    assign rdata = rd_sel ? 32'(r_w) : '0;
    assign w_unused = ^wdata[31:WW];
  end

endmodule

module ising_recursive_matrix #(
  parameter int N           = 8,
  parameter int NUM_WEIGHTS = 5,
  parameter int NUM_LUTS    = 2,
  parameter int DIAGONAL    = 0
) (
  input  logic               clk,
  input  logic               axi_rstn,
  input  logic               ising_rstn,
  input  logic [N-1:0]       lin,
  input  logic [N-1:0]       rin,
  input  logic [N-1:0]       tin,
  input  logic [N-1:0]       bin,
  output logic [N-1:0]       lout,
  output logic [N-1:0]       rout,
  output logic [N-1:0]       tout,
  output logic [N-1:0]       bout,
  output logic [N-1:0]       right_col,
  input  logic               wready,
  input  logic               wr_match,
  input  logic [$clog2(N):0] s_addr,
  input  logic [$clog2(N):0] d_addr,
  input  logic               vh,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  localparam int AW = $clog2(N) + 1;

  if (N == 1) begin : g_leaf
    // With a 1-bit index, a set bit means index >= 1, i.e. out of range.
    logic w_sel;
    logic w_unused;

    assign w_sel    = wr_match & ~s_addr[0] & ~d_addr[0];
    assign w_unused = vh;

    ising_cell #(
      .SHORTED    (DIAGONAL != 0),
      .NUM_WEIGHTS(NUM_WEIGHTS)
    ) u_cell (
      .clk       (clk),
      .axi_rstn  (axi_rstn),
      .ising_rstn(ising_rstn),
      .lin       (lin[0]),
      .rin       (rin[0]),
      .tin       (tin[0]),
      .bin       (bin[0]),
      .lout      (lout[0]),
      .rout      (rout[0]),
      .tout      (tout[0]),
      .bout      (bout[0]),
      .spin      (right_col[0]),
      .we        (wready & w_sel),
      .rd_sel    (w_sel),
      .wdata     (wdata),
      .rdata     (rdata)
    );
  end else begin : g_split
    localparam int H   = N / 2;
    localparam int AWC = AW - 1;
    // Child index keeps the bits below the quadrant-select bit; the child's
    // own out-of-range bit is forced to zero.
    localparam logic [AWC-1:0] LOW_MASK = {AWC{1'b1}} >> 1;

    logic           w_oob;
    logic           w_qs;
    logic           w_qd;
    logic [AWC-1:0] w_s_sub;
    logic [AWC-1:0] w_d_sub;
    logic [3:0]     w_we;
    logic [31:0]    w_rd [4];
    logic [H-1:0]   w_rc [4];
    logic           w_unused;

    // Quadrant-to-quadrant edges: horizontal in the top/bottom halves,
    // vertical in the left/right halves.
    logic [H-1:0] w_tl_to_tr;
    logic [H-1:0] w_tr_to_tl;
    logic [H-1:0] w_bl_to_br;
    logic [H-1:0] w_br_to_bl;
    logic [H-1:0] w_tl_to_bl;
    logic [H-1:0] w_bl_to_tl;
    logic [H-1:0] w_tr_to_br;
    logic [H-1:0] w_br_to_tr;

    assign w_oob   = s_addr[AW-1] | d_addr[AW-1];
    assign w_qs    = s_addr[AW-2];
    assign w_qd    = d_addr[AW-2];
    assign w_s_sub = s_addr[AWC-1:0] & LOW_MASK;
    assign w_d_sub = d_addr[AWC-1:0] & LOW_MASK;

    // Quadrant order: 0=TL, 1=TR, 2=BL, 3=BR ({row bit, column bit}).
    assign w_we[0] = wready & ~w_oob & ~w_qd & ~w_qs;
    assign w_we[1] = wready & ~w_oob & ~w_qd &  w_qs;
    assign w_we[2] = wready & ~w_oob &  w_qd & ~w_qs;
    assign w_we[3] = wready & ~w_oob &  w_qd &  w_qs;

    always_comb begin
      rdata = '0;
      if (!w_oob) begin
        rdata = w_rd[{w_qd, w_qs}];
      end
    end

    assign right_col = (DIAGONAL != 0) ? {w_rc[3], w_rc[0]} : rout;
    assign w_unused  = ^{w_rc[0], w_rc[1], w_rc[2], w_rc[3]};

    ising_recursive_matrix #(
      .N(H), .NUM_WEIGHTS(NUM_WEIGHTS), .NUM_LUTS(NUM_LUTS), .DIAGONAL(DIAGONAL)
    ) u_tl (
      .clk(clk), .axi_rstn(axi_rstn), .ising_rstn(ising_rstn),
      .lin(lin[H-1:0]), .rin(w_tr_to_tl), .tin(tin[H-1:0]), .bin(w_bl_to_tl),
      .lout(lout[H-1:0]), .rout(w_tl_to_tr), .tout(tout[H-1:0]), .bout(w_tl_to_bl),
      .right_col(w_rc[0]), .wready(w_we[0]), .wr_match(wr_match),
      .s_addr(w_s_sub), .d_addr(w_d_sub), .vh(vh), .wdata(wdata), .rdata(w_rd[0])
    );

    ising_recursive_matrix #(
      .N(H), .NUM_WEIGHTS(NUM_WEIGHTS), .NUM_LUTS(NUM_LUTS), .DIAGONAL(0)
    ) u_tr (
      .clk(clk), .axi_rstn(axi_rstn), .ising_rstn(ising_rstn),
      .lin(w_tl_to_tr), .rin(rin[H-1:0]), .tin(tin[N-1:H]), .bin(w_br_to_tr),
      .lout(w_tr_to_tl), .rout(rout[H-1:0]), .tout(tout[N-1:H]), .bout(w_tr_to_br),
      .right_col(w_rc[1]), .wready(w_we[1]), .wr_match(wr_match),
      .s_addr(w_s_sub), .d_addr(w_d_sub), .vh(vh), .wdata(wdata), .rdata(w_rd[1])
    );

    ising_recursive_matrix #(
      .N(H), .NUM_WEIGHTS(NUM_WEIGHTS), .NUM_LUTS(NUM_LUTS), .DIAGONAL(0)
    ) u_bl (
      .clk(clk), .axi_rstn(axi_rstn), .ising_rstn(ising_rstn),
      .lin(lin[N-1:H]), .rin(w_br_to_bl), .tin(w_tl_to_bl), .bin(bin[H-1:0]),
      .lout(lout[N-1:H]), .rout(w_bl_to_br), .tout(w_bl_to_tl), .bout(bout[H-1:0]),
      .right_col(w_rc[2]), .wready(w_we[2]), .wr_match(wr_match),
      .s_addr(w_s_sub), .d_addr(w_d_sub), .vh(vh), .wdata(wdata), .rdata(w_rd[2])
    );

    ising_recursive_matrix #(
      .N(H), .NUM_WEIGHTS(NUM_WEIGHTS), .NUM_LUTS(NUM_LUTS), .DIAGONAL(DIAGONAL)
    ) u_br (
      .clk(clk), .axi_rstn(axi_rstn), .ising_rstn(ising_rstn),
      .lin(w_bl_to_br), .rin(rin[N-1:H]), .tin(w_tr_to_br), .bin(bin[N-1:H]),
      .lout(w_br_to_bl), .rout(rout[N-1:H]), .tout(w_br_to_tr), .bout(bout[N-1:H]),
      .right_col(w_rc[3]), .wready(w_we[3]), .wr_match(wr_match),
      .s_addr(w_s_sub), .d_addr(w_d_sub), .vh(vh), .wdata(wdata), .rdata(w_rd[3])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_ising_recursive_matrix.sv
`default_nettype none
// ============================================================================
// Module  : tb_ising_recursive_matrix
// Purpose : Directed self-checking bench. Three instances: N=4 for weight
//           access and phase reset, N=1 for the single spin loop, N=2 for
//           the two-row loop with different coupling weights.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ising_recursive_matrix;

  logic clk;
  logic axi_rstn;
  int   n_cmp;
  int   n_err;

  // ---------------- N=4 instance ----------------
  logic        ising_rstn4;
  logic [3:0]  lin4, rin4, tin4, bin4;
  logic [3:0]  lout4, rout4, tout4, bout4, rc4;
  logic        wready4, wr_match4, vh4;
  logic [2:0]  s_addr4, d_addr4;
  logic [31:0] wdata4, rdata4;

  // ---------------- N=1 instance ----------------
  logic        ising_rstn1;
  logic [0:0]  lout1, rout1, tout1, bout1, rc1;
  logic [31:0] rdata1;

  // ---------------- N=2 instance ----------------
  logic        ising_rstn2;
  logic [1:0]  lout2, rout2, tout2, bout2, rc2;
  logic        wready2, wr_match2;
  logic [1:0]  s_addr2, d_addr2;
  logic [31:0] wdata2, rdata2;

  ising_recursive_matrix #(.N(4), .NUM_WEIGHTS(5), .NUM_LUTS(2), .DIAGONAL(1)) u_dut4 (
    .clk(clk), .axi_rstn(axi_rstn), .ising_rstn(ising_rstn4),
    .lin(lin4), .rin(rin4), .tin(tin4), .bin(bin4),
    .lout(lout4), .rout(rout4), .tout(tout4), .bout(bout4), .right_col(rc4),
    .wready(wready4), .wr_match(wr_match4), .s_addr(s_addr4), .d_addr(d_addr4),
    .vh(vh4), .wdata(wdata4), .rdata(rdata4)
  );

  ising_recursive_matrix #(.N(1), .NUM_WEIGHTS(5), .NUM_LUTS(2), .DIAGONAL(1)) u_dut1 (
    .clk(clk), .axi_rstn(axi_rstn), .ising_rstn(ising_rstn1),
    .lin(1'b0), .rin(1'b0), .tin(rout1), .bin(1'b0),
    .lout(lout1), .rout(rout1), .tout(tout1), .bout(bout1), .right_col(rc1),
    .wready(1'b0), .wr_match(1'b0), .s_addr(1'b0), .d_addr(1'b0),
    .vh(1'b0), .wdata(32'd0), .rdata(rdata1)
  );

  ising_recursive_matrix #(.N(2), .NUM_WEIGHTS(5), .NUM_LUTS(2), .DIAGONAL(1)) u_dut2 (
    .clk(clk), .axi_rstn(axi_rstn), .ising_rstn(ising_rstn2),
    .lin(2'b00), .rin(2'b00), .tin(rout2), .bin(2'b00),
    .lout(lout2), .rout(rout2), .tout(tout2), .bout(bout2), .right_col(rc2),
    .wready(wready2), .wr_match(wr_match2), .s_addr(s_addr2), .d_addr(d_addr2),
    .vh(1'b0), .wdata(wdata2), .rdata(rdata2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr4(input int d, input int s, input logic [31:0] data);
    d_addr4 = 3'(d); s_addr4 = 3'(s); vh4 = (s > d);
    wdata4 = data; wr_match4 = 1'b1; wready4 = 1'b1;
    tick();
    wready4 = 1'b0;
  endtask

  task automatic rd4(input int d, input int s, input logic match, input logic [31:0] exp, input string tag);
    d_addr4 = 3'(d); s_addr4 = 3'(s); vh4 = (s > d); wr_match4 = match;
    #1;
    check($sformatf("%s(%0d,%0d)", tag, d, s), rdata4, exp);
  endtask

  task automatic wr2(input int d, input int s, input logic [31:0] data);
    d_addr2 = 2'(d); s_addr2 = 2'(s); wdata2 = data;
    wr_match2 = 1'b1; wready2 = 1'b1;
    tick();
    wready2 = 1'b0;
  endtask

  // Hand-computed sequences, bit k = value after the k-th edge since release.
  logic [12:0] r1_seq;

  // Entered with the N=2 phase state freshly reset and ising_rstn2 low.
  task automatic run2(input string tag, input logic [12:0] e_r0, input logic [12:0] e_a0, input int n);
    check($sformatf("%s r0 k0", tag), 32'(rout2), 32'd0);
    ising_rstn2 = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("%s rout0 k%0d", tag, k), 32'(rout2[0]), 32'(e_r0[k]));
      check($sformatf("%s rout1 k%0d", tag, k), 32'(rout2[1]), 32'(r1_seq[k]));
      check($sformatf("%s rc0 k%0d", tag, k), 32'(rc2[0]), 32'(e_a0[k]));
      check($sformatf("%s rc1 k%0d", tag, k), 32'(rc2[1]), 32'(r1_seq[k]));
    end
  endtask

  initial begin
    logic [12:0] neu_r0, neu_a0, w0_r0, w0_a0, w4_r0, w4_a0;
    logic [3:0]  rc_exp [4];

    n_cmp = 0; n_err = 0;
    clk = 1'b0;
    axi_rstn = 1'b0;
    ising_rstn1 = 1'b0; ising_rstn2 = 1'b0; ising_rstn4 = 1'b0;
    lin4 = '0; rin4 = '0; tin4 = '0; bin4 = '0;
    wready4 = 1'b0; wr_match4 = 1'b0; vh4 = 1'b0; s_addr4 = '0; d_addr4 = '0; wdata4 = '0;
    wready2 = 1'b0; wr_match2 = 1'b0; s_addr2 = '0; d_addr2 = '0; wdata2 = '0;

    r1_seq = 13'b0_0110_0110_0110;
    neu_r0 = 13'b1_0000_1111_0000;
    neu_a0 = 13'b1_1110_0001_1110;
    w0_r0  = 13'b0_1100_1100_1100;
    w0_a0  = 13'b0_0110_0110_0110;
    w4_r0  = 13'b1_0011_0011_0000;
    w4_a0  = 13'b1_1001_1001_1110;
    rc_exp[0] = 4'b1110; rc_exp[1] = 4'b1100; rc_exp[2] = 4'b1000; rc_exp[3] = 4'b0000;

    tick();
    tick();
    axi_rstn = 1'b1;

    // Reset state of all phase outputs
    check("d4 reset outputs", 32'({lout4, rout4, tout4, bout4, rc4}), 32'd0);
    check("d1 reset rout", 32'(rout1), 32'd0);
    check("d2 reset rout", 32'(rout2), 32'd0);

    // Neutral weights after axi reset; diagonal and out-of-range read 0
    for (int d = 0; d < 4; d++)
      for (int s = 0; s < 4; s++)
        rd4(d, s, 1'b1, (d == s) ? 32'd0 : 32'd2, "rd default");
    rd4(0, 4, 1'b1, 32'd0, "rd s oob");
    rd4(4, 1, 1'b1, 32'd0, "rd d oob");
    rd4(0, 1, 1'b0, 32'd0, "rd no match");

    // Writes, clamping and ignored targets
    wr4(0, 1, 32'd4);  rd4(0, 1, 1'b1, 32'd4, "wr 4");
    wr4(2, 3, 32'd13); rd4(2, 3, 1'b1, 32'd4, "wr 13 clamp");
    wr4(3, 0, 32'd7);  rd4(3, 0, 1'b1, 32'd4, "wr 7 clamp");
    wr4(1, 0, 32'd3);  rd4(1, 0, 1'b1, 32'd3, "wr 3");
    wr4(1, 1, 32'd3);  rd4(1, 1, 1'b1, 32'd0, "wr diag ignored");
    wr4(1, 4, 32'd0);  rd4(1, 0, 1'b1, 32'd3, "wr oob no alias");
    rd4(3, 2, 1'b1, 32'd2, "untouched");

    // Strobe without wr_match must not write
    d_addr4 = 3'd0; s_addr4 = 3'd1; wdata4 = 32'd0; wr_match4 = 1'b0; wready4 = 1'b1;
    tick();
    wready4 = 1'b0;
    rd4(0, 1, 1'b1, 32'd4, "wr no match");

    // axi reset beats a simultaneous write
    d_addr4 = 3'd2; s_addr4 = 3'd3; wdata4 = 32'd0; wr_match4 = 1'b1; wready4 = 1'b1;
    axi_rstn = 1'b0;
    tick();
    wready4 = 1'b0; axi_rstn = 1'b1;
    rd4(2, 3, 1'b1, 32'd2, "axi rst over wr");
    rd4(0, 1, 1'b1, 32'd2, "axi rst other");
    rd4(1, 0, 1'b1, 32'd2, "axi rst other");

    // N=1 shorted loop toggles every cycle
    ising_rstn1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("d1 rout k%0d", k), 32'(rout1), (k % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("d1 rc k%0d", k), 32'(rc1), (k % 2 == 1) ? 32'd1 : 32'd0);
    end

    // N=2 loop, neutral coupling
    run2("neutral", neu_r0, neu_a0, 12);
    ising_rstn2 = 1'b0;
    tick();

    // Coupling weight 0, then a reset pulse mid-run and a clean restart
    wr2(0, 1, 32'd0);
    d_addr2 = 2'd0; s_addr2 = 2'd1; wr_match2 = 1'b1;
    #1;
    check("d2 rd w0", rdata2, 32'd0);
    run2("w0", w0_r0, w0_a0, 6);
    ising_rstn2 = 1'b0;
    tick();
    check("d2 mid reset", 32'({rout2, rc2}), 32'd0);
    run2("w0 restart", w0_r0, w0_a0, 12);
    ising_rstn2 = 1'b0;
    tick();

    // Coupling weight 4: slow when agreeing, fast when disagreeing
    wr2(0, 1, 32'd4);
    run2("w4", w4_r0, w4_a0, 12);
    ising_rstn2 = 1'b0;

    // N=4: downward phase walks through one register per coupled cell
    tin4 = 4'hF;
    ising_rstn4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("d4 rc walk %0d", k + 1), 32'(rc4), 32'(rc_exp[k]));
    end

    // Reset while inputs keep toggling: all outputs zero and held
    for (int k = 0; k < 8; k++) begin
      lin4 = 4'($urandom); rin4 = 4'($urandom); tin4 = 4'($urandom); bin4 = 4'($urandom);
      tick();
    end
    ising_rstn4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lin4 = 4'($urandom); rin4 = 4'($urandom); tin4 = 4'($urandom); bin4 = 4'($urandom);
      tick();
      check($sformatf("d4 ising rst %0d", k), 32'({lout4, rout4, tout4, bout4, rc4}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
